corr_search_dispatcher: RTL

Sequences the template-correlation search over a captured frame. It generates the X/Y candidate coordinates in raster order and dispatches them to `NUM_ENG` parallel correlation engines with a start/done handshake. It collects each engine's correlation result and tracks the maximum and its coordinate. It sits between the frame-capture logic, which asserts `iStart` once a frame is stored, and the bank of correlation engines; its best-match outputs feed the display/overlay logic.

---
 rtl/corr_search_dispatcher_if.sv | 32 +++
 rtl/corr_search_dispatcher.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/corr_search_dispatcher_if.sv
// Start/done and result bus between the search dispatcher, the frame-capture
// logic and the correlation-engine bank.
interface corr_search_dispatcher_if #(
   parameter int NUM_ENG = 2,
   parameter int CW      = 13,
   parameter int DW      = 32
);
   logic                  iStart;
   logic                  oBusy;
   logic                  oDone;
   logic [NUM_ENG-1:0]    oEngStart;
   logic [NUM_ENG*CW-1:0] oEngX;
   logic [NUM_ENG*CW-1:0] oEngY;
   logic [NUM_ENG-1:0]    iEngDone;
   logic [NUM_ENG*DW-1:0] iEngCorr;
   logic [CW-1:0]         oBestX;
   logic [CW-1:0]         oBestY;
   logic [DW-1:0]         oBestCorr;
   logic [23:0]           oJobCount;

   modport master (
      output iStart, iEngDone, iEngCorr,
      input  oBusy, oDone, oEngStart, oEngX, oEngY,
             oBestX, oBestY, oBestCorr, oJobCount
   );

   modport slave (
      input  iStart, iEngDone, iEngCorr,
      output oBusy, oDone, oEngStart, oEngX, oEngY,
             oBestX, oBestY, oBestCorr, oJobCount
   );
endinterface

// File: rtl/corr_search_dispatcher.sv
// Raster-order candidate generator that farms coordinates out to a bank of
// correlation engines and keeps the best-scoring coordinate.
//
// state      | meaning
// S_IDLE     | waiting for the first iStart after reset
// S_DISPATCH | issuing candidates to free engines, retiring results
// S_DRAIN    | all candidates issued, waiting for busy engines to finish
// S_DONE     | search complete, results held until the next iStart
module corr_search_dispatcher #(
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int STEP    = 1,
   parameter int NUM_ENG = 2,
   parameter int CW      = 13,
   parameter int DW      = 32
) (
   input  logic                    iCLK,
   input  logic                    iRST_N,
   corr_search_dispatcher_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_e;

   state_e                     state_q;
   logic                       busy_q;
   logic                       done_q;
   logic [CW-1:0]              x_q;
   logic [CW-1:0]              y_q;
   logic                       all_issued_q;
   logic [NUM_ENG-1:0]         eng_busy_q;
   logic [NUM_ENG-1:0]         eng_start_q;
   logic [NUM_ENG-1:0][CW-1:0] eng_x_q;
   logic [NUM_ENG-1:0][CW-1:0] eng_y_q;
   logic                       best_valid_q, best_valid_d;
   logic [CW-1:0]              best_x_q, best_x_d;
   logic [CW-1:0]              best_y_q, best_y_d;
   logic [DW-1:0]              best_corr_q, best_corr_d;
   logic [23:0]                job_cnt_q, job_cnt_d;

   logic                       active;
   logic                       dispatch_en;
   logic                       free_found;
   logic                       x_wrap;
   logic                       y_last;
   logic [NUM_ENG-1:0]         retire;
   logic [NUM_ENG-1:0]         disp_sel;
   logic [CW:0]                x_sum;
   logic [CW:0]                y_sum;
   logic [DW-1:0]              corr;

   // Dones from engines we never started (or from before a reset) must not retire.
   assign active = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
   assign retire = active ? (bus.iEngDone & eng_busy_q) : '0;

   assign x_sum  = {1'b0, x_q} + (CW+1)'(STEP);
   assign y_sum  = {1'b0, y_q} + (CW+1)'(STEP);
   assign x_wrap = (x_sum >= (CW+1)'(H_RES));
   assign y_last = (y_sum >= (CW+1)'(V_RES));

   always_comb begin
      disp_sel   = '0;
      free_found = 1'b0;
      for (int i = 0; i < NUM_ENG; i++) begin
         if (!eng_busy_q[i] && !free_found) begin
            disp_sel[i] = 1'b1;
            free_found  = 1'b1;
         end
      end
   end

   assign dispatch_en = (state_q == S_DISPATCH) && !all_issued_q && free_found;

   // Ascending engine order with strict '>' gives ties to the lower index.
   always_comb begin
      best_valid_d = best_valid_q;
      best_x_d     = best_x_q;
      best_y_d     = best_y_q;
      best_corr_d  = best_corr_q;
      job_cnt_d    = job_cnt_q;
      corr         = '0;
      for (int i = 0; i < NUM_ENG; i++) begin
         if (retire[i]) begin
            corr = bus.iEngCorr[i*DW +: DW];
            if (!best_valid_d || (corr > best_corr_d)) begin
               best_corr_d = corr;
               best_x_d    = eng_x_q[i];
               best_y_d    = eng_y_q[i];
            end
            best_valid_d = 1'b1;
            job_cnt_d    = job_cnt_d + 24'd1;
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_q      <= S_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         all_issued_q <= 1'b0;
         eng_busy_q   <= '0;
         eng_start_q  <= '0;
         eng_x_q      <= '0;
         eng_y_q      <= '0;
         best_valid_q <= 1'b0;
         best_x_q     <= '0;
         best_y_q     <= '0;
         best_corr_q  <= '0;
         job_cnt_q    <= '0;
      end else begin
         eng_start_q <= '0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.iStart) begin
                  state_q      <= S_DISPATCH;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  x_q          <= '0;
                  y_q          <= '0;
                  all_issued_q <= 1'b0;
                  eng_busy_q   <= '0;
                  best_valid_q <= 1'b0;
                  job_cnt_q    <= '0;
               end
            end
            S_DISPATCH: begin
               if (dispatch_en) begin
                  eng_start_q <= disp_sel;
                  for (int i = 0; i < NUM_ENG; i++) begin
                     if (disp_sel[i]) begin
                        eng_x_q[i] <= x_q;
                        eng_y_q[i] <= y_q;
                     end
                  end
                  if (x_wrap) begin
                     x_q <= '0;
                     if (y_last) begin
                        all_issued_q <= 1'b1;
                     end else begin
                        y_q <= y_sum[CW-1:0];
                     end
                  end else begin
                     x_q <= x_sum[CW-1:0];
                  end
               end
               if (all_issued_q) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (eng_busy_q == '0) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
         if (active) begin
            eng_busy_q   <= (eng_busy_q & ~retire) | (dispatch_en ? disp_sel : '0);
            best_valid_q <= best_valid_d;
            best_x_q     <= best_x_d;
            best_y_q     <= best_y_d;
            best_corr_q  <= best_corr_d;
            job_cnt_q    <= job_cnt_d;
         end
      end
   end

   assign bus.oBusy     = busy_q;
   assign bus.oDone     = done_q;
   assign bus.oEngStart = eng_start_q;
   assign bus.oEngX     = eng_x_q;
   assign bus.oEngY     = eng_y_q;
   assign bus.oBestX    = best_x_q;
   assign bus.oBestY    = best_y_q;
   assign bus.oBestCorr = best_corr_q;
   assign bus.oJobCount = job_cnt_q;
endmodule
